// File: rtl/fft_axis_pkg.sv
// Shared constants and types for the FFT FIFO to AXI-Stream read bridge.
// Frame length, index width and frame counter width defaults live here.
package fft_axis_pkg;
   localparam int FRAME_LEN_DEF = 1024;
   localparam int CNT_WIDTH_DEF = 16;
   localparam int FCNT_W        = 16;

   typedef logic [1:0] occ_t;
endpackage

// File: rtl/fft_axis_skid_buf.sv
// Two-entry in-order skid buffer between the FIFO read port and AXI-Stream.
// Head entry is always r_d0; r_d1 only holds data when occupancy is 2.
module fft_axis_skid_buf
   import fft_axis_pkg::*;
#(
   parameter int DATA_WIDTH = 32
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_push,
   input  logic                  i_pop,
   input  logic [DATA_WIDTH-1:0] i_data,
   output logic [DATA_WIDTH-1:0] o_head,
   output occ_t                  o_occ,
   output logic                  o_empty
);

   logic [DATA_WIDTH-1:0] r_d0;
   logic [DATA_WIDTH-1:0] r_d1;
   occ_t                  r_occ;
   occ_t                  w_occ_nxt;

   assign w_occ_nxt = r_occ + {1'b0, i_push} - {1'b0, i_pop};
   assign o_head    = r_d0;
   assign o_occ     = r_occ;
   assign o_empty   = (r_occ == 2'd0);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_occ <= '0;
      end else begin
         r_occ <= w_occ_nxt;
      end
   end

   // Data entries carry no reset; occupancy alone qualifies them.
   always_ff @(posedge i_clk) begin
      if (i_push) begin
         if (r_occ == 2'd0 || (r_occ == 2'd1 && i_pop)) begin
            r_d0 <= i_data;
         end else if (r_occ == 2'd1) begin
            r_d1 <= i_data;
         end else if (i_pop) begin
            r_d0 <= r_d1;
            r_d1 <= i_data;
         end
      end else if (i_pop && r_occ == 2'd2) begin
         r_d0 <= r_d1;
      end
   end

   a_no_overflow : assert property (@(posedge i_clk) disable iff (i_rst)
      !(i_push && !i_pop && r_occ == 2'd2));

   a_no_underflow : assert property (@(posedge i_clk) disable iff (i_rst)
      !(i_pop && r_occ == 2'd0));

endmodule

// File: rtl/fft_fifo_axis_rd_bridge.sv
// Drains a FIFO with 1-cycle read latency into an AXI-Stream master,
// framing samples with tuser (index 0) and tlast (index FRAME_LEN-1).
module fft_fifo_axis_rd_bridge
   import fft_axis_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int FRAME_LEN  = FRAME_LEN_DEF,
   parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
   input  logic                  rd_clk,
   input  logic                  rd_rst,
   output logic                  fifo_rd_en,
   input  logic                  fifo_rd_empty,
   input  logic [DATA_WIDTH-1:0] fifo_rd_data,
   input  logic                  frame_restart,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic                  m_axis_tuser,
   output logic [FCNT_W-1:0]     frame_count
);

   localparam logic [CNT_WIDTH-1:0] LAST_IDX = CNT_WIDTH'(FRAME_LEN - 1);

   logic                 r_inflight;
   logic                 r_rst_pend;
   logic [CNT_WIDTH-1:0] r_idx;
   logic [FCNT_W-1:0]    r_fcnt;

   logic                 w_pop;
   logic                 w_empty;
   logic                 w_at_last;
   occ_t                 w_occ;
   logic [2:0]           w_level;

   fft_axis_skid_buf #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_skid (
      .i_clk   (rd_clk),
      .i_rst   (rd_rst),
      .i_push  (r_inflight),
      .i_pop   (w_pop),
      .i_data  (fifo_rd_data),
      .o_head  (m_axis_tdata),
      .o_occ   (w_occ),
      .o_empty (w_empty)
   );

   // Level counts buffered plus in-flight words after this cycle's pop.
   assign w_level = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};

   assign fifo_rd_en    = !rd_rst && !fifo_rd_empty && (w_level < 3'd2);
   assign m_axis_tvalid = !rd_rst && !w_empty;
   assign w_pop         = m_axis_tvalid && m_axis_tready;
   assign w_at_last     = (r_idx == LAST_IDX);
   assign m_axis_tuser  = m_axis_tvalid && (r_idx == '0);
   assign m_axis_tlast  = m_axis_tvalid && w_at_last;
   assign frame_count   = r_fcnt;

   // A restart seen while a beat is already presented is deferred so the
   // presented beat's flags stay stable until it is accepted.
   always_ff @(posedge rd_clk) begin
      if (rd_rst) begin
         r_inflight <= 1'b0;
         r_rst_pend <= 1'b0;
         r_idx      <= '0;
         r_fcnt     <= '0;
      end else begin
         r_inflight <= fifo_rd_en;
         if (w_pop) begin
            r_rst_pend <= 1'b0;
            if (frame_restart || r_rst_pend || w_at_last) begin
               r_idx <= '0;
            end else begin
               r_idx <= r_idx + CNT_WIDTH'(1);
            end
            if (m_axis_tlast) begin
               r_fcnt <= r_fcnt + FCNT_W'(1);
            end
         end else if (frame_restart) begin
            if (m_axis_tvalid) begin
               r_rst_pend <= 1'b1;
            end else begin
               r_idx <= '0;
            end
         end
      end
   end

endmodule

// File: tb/tb_fft_fifo_axis_rd_bridge.sv
// Scoreboard bench: stimulus queues expected beats, a negedge monitor
// pops and compares them on every AXI-Stream handshake.
module tb_fft_fifo_axis_rd_bridge;

   logic        clk;
   logic        rst;
   logic        rd_en;
   logic        fifo_empty;
   logic [31:0] rd_data;
   logic        restart;
   logic [31:0] tdata;
   logic        tvalid;
   logic        tready;
   logic        tlast;
   logic        tuser;
   logic [15:0] fcnt;

   typedef struct {
      logic [31:0] d;
      logic        u;
      logic        l;
      int          c;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] fq[$];
   int          n_push = 0;
   int          n_pop  = 0;
   int          cyc    = 0;
   int          n_cmp  = 0;
   int          n_bad  = 0;
   logic        prev_stall = 1'b0;
   logic [33:0] prev_bus;

   fft_fifo_axis_rd_bridge #(
      .DATA_WIDTH (32),
      .FRAME_LEN  (4),
      .CNT_WIDTH  (4)
   ) dut (
      .rd_clk        (clk),
      .rd_rst        (rst),
      .fifo_rd_en    (rd_en),
      .fifo_rd_empty (fifo_empty),
      .fifo_rd_data  (rd_data),
      .frame_restart (restart),
      .m_axis_tdata  (tdata),
      .m_axis_tvalid (tvalid),
      .m_axis_tready (tready),
      .m_axis_tlast  (tlast),
      .m_axis_tuser  (tuser),
      .frame_count   (fcnt)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   assign fifo_empty = (n_push == n_pop);

   always @(posedge clk) cyc <= cyc + 1;

   // FIFO model: data valid one cycle after rd_en, reset with the DUT.
   always @(posedge clk) begin
      if (rst) begin
         fq.delete();
         n_pop <= n_push;
      end else if (rd_en && fq.size() != 0) begin
         rd_data <= fq.pop_front();
         n_pop   <= n_pop + 1;
      end
   end

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (rd_en) chk("rd_en_while_empty", 64'(fifo_empty), 64'd0);
         if (prev_stall) begin
            chk("hold_valid", 64'(tvalid), 64'd1);
            chk("hold_bus", 64'({tdata, tuser, tlast}), 64'(prev_bus));
         end
         if (tvalid && tready) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_beat: got %0h expected none", tdata);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("tdata", 64'(tdata), 64'(e.d));
               chk("tuser", 64'(tuser), 64'(e.u));
               chk("tlast", 64'(tlast), 64'(e.l));
               if (e.c >= 0) chk("beat_cycle", 64'(cyc), 64'(e.c));
            end
         end
         prev_stall = tvalid && !tready;
         prev_bus   = {tdata, tuser, tlast};
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put_fifo(input logic [31:0] d);
      fq.push_back(d);
      n_push++;
   endtask

   task automatic put(input logic [31:0] d, input logic u, input logic l,
                      input int c);
      put_fifo(d);
      sb.push_back('{d, u, l, c});
   endtask

   task automatic drain(input string nm, input int bound);
      int n;
      n = 0;
      while ((sb.size() != 0 || n_push != n_pop) && n < bound) begin
         tick();
         n++;
      end
      tick();
      chk(nm, 64'(n < bound), 64'd1);
   endtask

   initial begin
      int base;
      int cnt;
      rst     = 1'b1;
      tready  = 1'b0;
      restart = 1'b0;
      repeat (3) tick();
      @(negedge clk);
      chk("rst_rd_en", 64'(rd_en), 64'd0);
      chk("rst_tvalid", 64'(tvalid), 64'd0);
      chk("rst_tlast", 64'(tlast), 64'd0);
      chk("rst_tuser", 64'(tuser), 64'd0);
      chk("rst_fcnt", 64'(fcnt), 64'd0);
      tick();
      rst = 1'b0;
      repeat (2) tick();

      // Back-to-back stream, two full frames
      tready = 1'b1;
      base = cyc;
      for (int i = 0; i < 8; i++)
         put(32'(i), (i % 4) == 0, (i % 4) == 3, base + 2 + i);
      drain("drain_burst", 40);
      chk("fcnt_burst", 64'(fcnt), 64'd2);

      // Toggling ready
      for (int i = 0; i < 8; i++)
         put(32'(i), (i % 4) == 0, (i % 4) == 3, -1);
      for (int i = 0; i < 60 && sb.size() != 0; i++) begin
         tick();
         tready = ~tready;
      end
      tready = 1'b1;
      drain("drain_toggle", 40);
      chk("fcnt_toggle", 64'(fcnt), 64'd4);

      // Stalled sink against a full FIFO
      tready = 1'b0;
      for (int i = 0; i < 8; i++)
         put(32'(i), (i % 4) == 0, (i % 4) == 3, -1);
      cnt = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (rd_en) cnt++;
         tick();
      end
      chk("stall_reads", 64'(cnt), 64'd2);
      @(negedge clk);
      chk("stall_tvalid", 64'(tvalid), 64'd1);
      chk("stall_tdata", 64'(tdata), 64'd0);
      chk("stall_rd_en", 64'(rd_en), 64'd0);
      tick();
      tready = 1'b1;
      drain("drain_stall", 40);
      chk("fcnt_stall", 64'(fcnt), 64'd6);

      // Restart coinciding with the index-2 beat
      tready = 1'b0;
      put(32'h10, 1'b1, 1'b0, -1);
      put(32'h11, 1'b0, 1'b0, -1);
      put(32'h12, 1'b0, 1'b0, -1);
      put(32'h13, 1'b1, 1'b0, -1);
      put(32'h14, 1'b0, 1'b0, -1);
      put(32'h15, 1'b0, 1'b0, -1);
      repeat (5) tick();
      tready = 1'b1;
      repeat (2) tick();
      restart = 1'b1;
      tick();
      restart = 1'b0;
      drain("drain_restart", 40);
      chk("fcnt_restart", 64'(fcnt), 64'd6);
      // Restart while idle realigns the next beat to index 0
      restart = 1'b1;
      tick();
      restart = 1'b0;
      put(32'h16, 1'b1, 1'b0, -1);
      drain("drain_idle_restart", 20);
      chk("fcnt_idle_restart", 64'(fcnt), 64'd6);

      // Reset with a read in flight
      tready = 1'b0;
      for (int i = 0; i < 4; i++) put_fifo(32'h20 + 32'(i));
      @(negedge clk);
      chk("pre_rst_rd_en", 64'(rd_en), 64'd1);
      tick();
      rst = 1'b1;
      @(negedge clk);
      chk("rst_gates_rd_en", 64'(rd_en), 64'd0);
      tick();
      @(negedge clk);
      chk("mid_rst_tvalid", 64'(tvalid), 64'd0);
      chk("mid_rst_tuser", 64'(tuser), 64'd0);
      chk("mid_rst_tlast", 64'(tlast), 64'd0);
      chk("mid_rst_fcnt", 64'(fcnt), 64'd0);
      chk("mid_rst_rd_en", 64'(rd_en), 64'd0);
      tick();
      rst = 1'b0;
      tick();
      tready = 1'b1;
      base = cyc;
      for (int i = 0; i < 4; i++)
         put(32'h30 + 32'(i), i == 0, i == 3, base + 2 + i);
      drain("drain_post_rst", 30);
      chk("fcnt_post_rst", 64'(fcnt), 64'd1);

      // Trickle feed: one word every 3 cycles
      for (int i = 0; i < 4; i++) begin
         put(32'h40 + 32'(i), i == 0, i == 3, cyc + 2);
         @(negedge clk);
         chk("gap_tvalid_a", 64'(tvalid), 64'd0);
         tick();
         @(negedge clk);
         chk("gap_tvalid_b", 64'(tvalid), 64'd0);
         tick();
         tick();
      end
      drain("drain_trickle", 20);
      chk("fcnt_trickle", 64'(fcnt), 64'd2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
